// File: rtl/seg7_count_display.sv
// Display stage for an 8-bit count: sequential double-dabble to 3 BCD digits, then time-multiplexed 7-segment scan.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero hundreds/tens digits.
module seg7_count_display #(
   parameter int unsigned SCAN_DIV       = 50000,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
   input  logic       clk50m,
   input  logic       reset,
   input  logic [7:0] value,
   output logic [6:0] seg,
   output logic [2:0] an,
   output logic       busy
);

   localparam int unsigned PW      = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [2:0] AN_OFF   = AN_ACTIVE_LOW  ? 3'b111 : 3'b000;
   localparam logic [6:0] SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F  : 7'h00;

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t        state, state_nxt;
   logic [7:0]    cap, cap_nxt;
   logic [19:0]   sr, sr_nxt;
   logic [2:0]    bitcnt, bitcnt_nxt;
   logic [3:0]    h, t, o, h_nxt, t_nxt, o_nxt;

   logic [PW-1:0] presc, presc_nxt;
   logic [1:0]    idx, idx_nxt;
   logic [2:0]    an_nxt;
   logic [6:0]    seg_nxt;
   logic [3:0]    dig;
   logic          blank, blank_h, blank_t;

   // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
   function automatic logic [19:0] dabble(input logic [19:0] s);
      logic [19:0] a;
      a = s;
      if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
      if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
      if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
      return {a[18:0], 1'b0};
   endfunction

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] c;
      case (d)
         4'd0:    c = 7'h3F;
         4'd1:    c = 7'h06;
         4'd2:    c = 7'h5B;
         4'd3:    c = 7'h4F;
         4'd4:    c = 7'h66;
         4'd5:    c = 7'h6D;
         4'd6:    c = 7'h7D;
         4'd7:    c = 7'h07;
         4'd8:    c = 7'h7F;
         4'd9:    c = 7'h6F;
         default: c = 7'h00;
      endcase
      return c;
   endfunction

   assign busy = (state != IDLE);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt  = state;
      cap_nxt    = cap;
      sr_nxt     = sr;
      bitcnt_nxt = bitcnt;
      h_nxt      = h;
      t_nxt      = t;
      o_nxt      = o;
      case (state)
         IDLE: begin
            if (value != cap) begin
               cap_nxt    = value;
               sr_nxt     = {12'd0, value};
               bitcnt_nxt = 3'd0;
               state_nxt  = CONV;
            end
         end
         CONV: begin
            sr_nxt     = dabble(sr);
            bitcnt_nxt = bitcnt + 3'd1;
            if (bitcnt == 3'd7) state_nxt = DONE;
         end
         DONE: begin
            h_nxt     = sr[19:16];
            t_nxt     = sr[15:12];
            o_nxt     = sr[11:8];
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk50m) begin
      // NOTE: reset is synchronous; it is only an ordinary term of the clocked update.
      if (!reset) begin
         state  <= IDLE;
         cap    <= '0;
         sr     <= '0;
         bitcnt <= '0;
         h      <= '0;
         t      <= '0;
         o      <= '0;
      end else begin
         state  <= state_nxt;
         cap    <= cap_nxt;
         sr     <= sr_nxt;
         bitcnt <= bitcnt_nxt;
         h      <= h_nxt;
         t      <= t_nxt;
         o      <= o_nxt;
      end
   end

   always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
      blank_h = (h == 4'd0);
      blank_t = (h == 4'd0) && (t == 4'd0);
`else
      blank_h = 1'b0;
      blank_t = 1'b0;
`endif
      presc_nxt = presc + PW'(1);
      idx_nxt   = idx;
      if (presc == PRESC_LAST) begin
         presc_nxt = '0;
         idx_nxt   = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end
      dig   = o;
      blank = 1'b0;
      case (idx)
         2'd0:    begin dig = o; blank = 1'b0;    end
         2'd1:    begin dig = t; blank = blank_t; end
         2'd2:    begin dig = h; blank = blank_h; end
         default: begin dig = o; blank = 1'b1;    end
      endcase
      // A blanked slot keeps its enable inactive but still occupies its scan time.
      if (blank) begin
         an_nxt  = AN_OFF;
         seg_nxt = SEG_OFF;
      end else begin
         an_nxt  = AN_ACTIVE_LOW  ? ~(3'b001 << idx) : (3'b001 << idx);
         seg_nxt = SEG_ACTIVE_LOW ? ~decode(dig)    : decode(dig);
      end
   end

   always_ff @(posedge clk50m) begin
      if (!reset) begin
         presc <= '0;
         idx   <= '0;
         an    <= AN_OFF;
         seg   <= SEG_OFF;
      end else begin
         presc <= presc_nxt;
         idx   <= idx_nxt;
         an    <= an_nxt;
         seg   <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_seg7_count_display.sv
// Directed bench for seg7_count_display with SCAN_DIV=4 and active-low segments/anodes.
module tb_seg7_count_display;

   logic       clk50m;
   logic       reset;
   logic [7:0] value;
   logic [6:0] seg;
   logic [2:0] an;
   logic       busy;

   int total;
   int bad;

   seg7_count_display #(
      .SCAN_DIV      (4),
      .SEG_ACTIVE_LOW(1'b1),
      .AN_ACTIVE_LOW (1'b1)
   ) dut (
      .clk50m(clk50m),
      .reset (reset),
      .value (value),
      .seg   (seg),
      .an    (an),
      .busy  (busy)
   );

   initial clk50m = 1'b0;
   always #5 clk50m = ~clk50m;

   task automatic step();
      @(posedge clk50m);
      #1;
   endtask

   // Counts consecutive samples with busy high, starting from the current sample.
   task automatic count_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         step();
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 60) begin
         n++;
         step();
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL %s: busy still %b after %0d cycles, required 0", name, busy, n);
      end
   endtask

   // Samples exactly one full scan period (3 slots x 4 cycles).
   task automatic read_digits(output logic [6:0] so, output logic [6:0] st,
                              output logic [6:0] sh, output int nblank, output int nodd);
      so = 7'bx; st = 7'bx; sh = 7'bx;
      nblank = 0; nodd = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         case (an)
            3'b110: so = seg;
            3'b101: st = seg;
            3'b011: sh = seg;
            3'b111: begin
               nblank++;
               if (seg !== 7'h7F) nodd++;
            end
            default: nodd++;
         endcase
      end
   endtask

   task automatic check_digits(input string name, input logic [6:0] eo,
                               input logic [6:0] et, input logic [6:0] eh,
                               input int eblank);
      logic [6:0] so, st, sh;
      int nblank, nodd;
      read_digits(so, st, sh, nblank, nodd);
      total++;
      if (so !== eo) begin
         bad++;
         $display("FAIL %s ones: seg=%h required %h", name, so, eo);
      end
      if (eblank < 4) begin
         total++;
         if (st !== et) begin
            bad++;
            $display("FAIL %s tens: seg=%h required %h", name, st, et);
         end
      end
      if (eblank < 8) begin
         total++;
         if (sh !== eh) begin
            bad++;
            $display("FAIL %s hundreds: seg=%h required %h", name, sh, eh);
         end
      end
      total++;
      if (nblank !== eblank || nodd !== 0) begin
         bad++;
         $display("FAIL %s blanking: blank_cycles=%0d odd=%0d required %0d/0",
                  name, nblank, nodd, eblank);
      end
   endtask

   task automatic test_reset();
      logic [2:0] exp_an;
      reset = 1'b0;
      value = 8'd0;
      repeat (3) step();
      total++;
      if (an !== 3'b111 || seg !== 7'h7F || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: an=%b seg=%h busy=%b required 111/7f/0", an, seg, busy);
      end
      reset = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         case (i / 4)
            0:       exp_an = 3'b110;
`ifdef LEADING_ZERO_BLANK_EN
            1:       exp_an = 3'b111;
            2:       exp_an = 3'b111;
`else
            1:       exp_an = 3'b101;
            2:       exp_an = 3'b011;
`endif
            default: exp_an = 3'b110;
         endcase
         total++;
         if (an !== exp_an || seg !== ((exp_an == 3'b111) ? 7'h7F : 7'h40)) begin
            bad++;
            $display("FAIL scan_cycle%0d: an=%b seg=%h required an=%b", i, an, seg, exp_an);
         end
      end
   endtask

   task automatic test_convert_255();
      int n;
      value = 8'd255;
      step();
      count_busy(n);
      total++;
      if (n !== 9) begin
         bad++;
         $display("FAIL busy_len_255: cycles=%0d required 9", n);
      end
      check_digits("digits_255", 7'h12, 7'h12, 7'h24, 0);
   endtask

   task automatic test_change_during_conv();
      int n1, n2;
      value = 8'd100;
      step();
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL start_100: busy=%b required 1", busy);
      end
      repeat (3) step();
      value = 8'd200;
      count_busy(n1);
      total++;
      if (n1 !== 6) begin
         bad++;
         $display("FAIL rest_of_100: busy cycles=%0d required 6", n1);
      end
      step();
      count_busy(n2);
      total++;
      if (n2 !== 9) begin
         bad++;
         $display("FAIL reconv_200: busy cycles=%0d required 9 after a 1-cycle gap", n2);
      end
      check_digits("digits_200", 7'h40, 7'h40, 7'h24, 0);
   endtask

   task automatic test_wrap();
      int n;
      value = 8'd255;
      step();
      wait_idle("idle_before_wrap");
      step();
      value = 8'd0;
      step();
      count_busy(n);
      total++;
      if (n !== 9) begin
         bad++;
         $display("FAIL busy_len_wrap: cycles=%0d required 9", n);
      end
      repeat (3) step();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL single_conv_wrap: busy=%b required 0", busy);
      end
`ifdef LEADING_ZERO_BLANK_EN
      check_digits("digits_0", 7'h40, 7'h7F, 7'h7F, 8);
`else
      check_digits("digits_0", 7'h40, 7'h40, 7'h40, 0);
`endif
   endtask

   task automatic test_reset_mid_conv();
      value = 8'd123;
      step();
      repeat (2) step();
      reset = 1'b0;
      step();
      total++;
      if (busy !== 1'b0 || an !== 3'b111 || seg !== 7'h7F) begin
         bad++;
         $display("FAIL abort: busy=%b an=%b seg=%h required 0/111/7f", busy, an, seg);
      end
      reset = 1'b1;
      step();
      total++;
      if (an !== 3'b110 || seg !== 7'h40 || busy !== 1'b1) begin
         bad++;
         $display("FAIL after_abort: an=%b seg=%h busy=%b required 110/40/1", an, seg, busy);
      end
      wait_idle("idle_123");
      check_digits("digits_123", 7'h30, 7'h24, 7'h79, 0);
   endtask

   task automatic test_leading_zero();
      value = 8'd7;
      step();
      wait_idle("idle_7");
`ifdef LEADING_ZERO_BLANK_EN
      check_digits("digits_7", 7'h78, 7'h7F, 7'h7F, 8);
`else
      check_digits("digits_7", 7'h78, 7'h40, 7'h40, 0);
`endif
      value = 8'd40;
      step();
      wait_idle("idle_40");
`ifdef LEADING_ZERO_BLANK_EN
      check_digits("digits_40", 7'h40, 7'h19, 7'h7F, 4);
`else
      check_digits("digits_40", 7'h40, 7'h19, 7'h40, 0);
`endif
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      value = 8'd0;
      test_reset();
      test_convert_255();
      test_change_during_conv();
      test_wrap();
      test_reset_mid_conv();
      test_leading_zero();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
